// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int         UART_DATA_BITS   = 8;
    localparam logic [3:0] RESP_TAG_DEFAULT = 4'hA;

    typedef enum logic [1:0] {
        RT_IDLE = 2'd0,
        RT_HDR  = 2'd1,
        RT_DATA = 2'd2
    } rt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BITS  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] resp_header(input logic [3:0] tag, input logic [2:0] addr);
        return {tag, addr, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 serialiser, LSB first, registered line output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_tx
);

    localparam int            CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    C_BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                   r_state;
    tx_state_t                   w_state_nxt;
    logic [CW-1:0]               r_baud;
    logic [2:0]                  r_bit;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic                        r_tx;
    logic                        r_done;
    logic                        w_baud_last;

    assign w_baud_last = (r_baud == C_BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:  if (i_valid)                              w_state_nxt = TX_START;
            TX_START: if (w_baud_last)                          w_state_nxt = TX_BITS;
            TX_BITS:  if (w_baud_last && r_bit == C_BIT_LAST)   w_state_nxt = TX_STOP;
            TX_STOP:  if (w_baud_last)                          w_state_nxt = TX_IDLE;
            default:                                            w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == TX_STOP) && w_baud_last;

            if ((w_state_nxt != r_state) || w_baud_last)
                r_baud <= '0;
            else if (r_state != TX_IDLE)
                r_baud <= r_baud + CW'(1);

            case (r_state)
                TX_IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_byte;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_baud_last)
                        r_tx <= r_shift[0];
                end
                TX_BITS: begin
                    // Shift register keeps the next bit at [1]; the index only detects the last bit
                    if (w_baud_last) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        r_tx    <= (r_bit == C_BIT_LAST) ? 1'b1 : r_shift[1];
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = (r_state == TX_IDLE);
    assign o_done  = r_done;
    assign o_tx    = r_tx;

endmodule
`default_nettype wire

// File: rtl/uart_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_resp_tx
//  Description : Builds a {header, data} read-response frame and sends it 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [3:0] RESP_TAG     = RESP_TAG_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_req,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_tx
);

    rt_state_t  r_state;
    rt_state_t  w_state_nxt;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    logic       w_tx_valid;
    logic [7:0] w_tx_byte;
    logic       w_tx_ready;
    logic       w_tx_done;
    logic       w_frame_done;
    logic       w_accept;

    assign w_accept = i_req && o_ready;

    // In HDR the sender is idle twice: first cycle (load header) and its done cycle (load data)
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_valid   = 1'b0;
        w_tx_byte    = resp_header(RESP_TAG, r_addr);
        w_frame_done = 1'b0;
        case (r_state)
            RT_IDLE: begin
                if (i_req) w_state_nxt = RT_HDR;
            end
            RT_HDR: begin
                w_tx_valid = w_tx_ready;
                if (w_tx_done) begin
                    w_tx_byte   = r_data;
                    w_state_nxt = RT_DATA;
                end
            end
            RT_DATA: begin
                if (w_tx_done) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = i_req ? RT_HDR : RT_IDLE;
                end
            end
            default: w_state_nxt = RT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= RT_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_valid (w_tx_valid),
        .i_byte  (w_tx_byte),
        .o_ready (w_tx_ready),
        .o_done  (w_tx_done),
        .o_tx    (o_tx)
    );

    assign o_ready = (r_state == RT_IDLE) || w_frame_done;
    assign o_busy  = ~o_ready;
    assign o_done  = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_resp_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_resp_tx
//  Description : Directed bench for uart_resp_tx (4 and 868 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_resp_tx;

    logic       clk = 1'b0;
    logic       nrst;
    logic       req_a, req_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       ready_a, busy_a, done_a, tx_a;
    logic       ready_b, busy_b, done_b, tx_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_resp_tx #(.CLKS_PER_BIT(4), .RESP_TAG(4'hA)) dut_a (
        .i_clk(clk), .i_nrst(nrst), .i_req(req_a), .i_addr(addr_a), .i_data(data_a),
        .o_ready(ready_a), .o_busy(busy_a), .o_done(done_a), .o_tx(tx_a)
    );

    uart_resp_tx #(.CLKS_PER_BIT(868), .RESP_TAG(4'hA)) dut_b (
        .i_clk(clk), .i_nrst(nrst), .i_req(req_b), .i_addr(addr_b), .i_data(data_b),
        .o_ready(ready_b), .o_busy(busy_b), .o_done(done_b), .o_tx(tx_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input bit sel);    return sel ? tx_b    : tx_a;    endfunction
    function automatic logic done_of(input bit sel);  return sel ? done_b  : done_a;  endfunction
    function automatic logic ready_of(input bit sel); return sel ? ready_b : ready_a; endfunction
    function automatic logic busy_of(input bit sel);  return sel ? busy_b  : busy_a;  endfunction

    // Entered at the negedge just after the accept edge; returns at the negedge of the o_done cycle.
    // Line groups: 0..9 header start/bits/stop, 10 load cycle, 11..20 data, 21 done cycle.
    task automatic run_frame(input string tag, input bit sel, input logic [7:0] hdr, input logic [7:0] dat);
        int   c;
        int   last;
        int   done_at;
        int   g;
        int   p;
        logic e;
        logic g_exp [22];
        logic g_obs [22];
        bit   g_seen[22];
        c       = sel ? 868 : 4;
        last    = 20 * c + 2;
        done_at = -1;
        for (int k = 0; k < 22; k++) g_seen[k] = 1'b0;
        check({tag, "_ready_drop"}, 32'(ready_of(sel)), 32'd0);
        check({tag, "_busy"},       32'(busy_of(sel)),  32'd1);
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            if (i <= 10 * c) begin
                p = (i - 1) / c;
                g = p;
                e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : hdr[p-1];
            end else if (i == 10 * c + 1) begin
                g = 10;
                e = 1'b1;
            end else if (i <= 20 * c + 1) begin
                p = (i - 10 * c - 2) / c;
                g = 11 + p;
                e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : dat[p-1];
            end else begin
                g = 21;
                e = 1'b1;
            end
            if (!g_seen[g]) begin
                g_seen[g] = 1'b1;
                g_exp[g]  = e;
                g_obs[g]  = e;
            end
            if (tx_of(sel) !== e) g_obs[g] = tx_of(sel);
            if (done_of(sel) && done_at < 0) done_at = i;
        end
        for (int k = 0; k < 22; k++)
            check($sformatf("%s_line_g%0d", tag, k), 32'(g_obs[k]), 32'(g_exp[k]));
        check({tag, "_done_cycle"},  32'(done_at), 32'(last));
        check({tag, "_ready_done"},  32'(ready_of(sel)), 32'd1);
    endtask

    initial begin
        int bad_tx, bad_rdy, bad_done;
        nrst = 1'b0;
        req_a = 1'b0; addr_a = '0; data_a = '0;
        req_b = 1'b0; addr_b = '0; data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(tx_a),    32'd1);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        nrst = 1'b1;

        bad_tx = 0; bad_rdy = 0; bad_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a    !== 1'b1) bad_tx++;
            if (ready_a !== 1'b1) bad_rdy++;
            if (done_a  !== 1'b0) bad_done++;
        end
        check("idle_tx_bad_cycles",    32'(bad_tx),   32'd0);
        check("idle_ready_bad_cycles", 32'(bad_rdy),  32'd0);
        check("idle_done_bad_cycles",  32'(bad_done), 32'd0);

        // Single read response
        addr_a = 3'd5; data_a = 8'h3C; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        run_frame("single", 1'b0, 8'hAA, 8'h3C);

        // Request held through a busy frame with different payload
        @(negedge clk);
        addr_a = 3'd5; data_a = 8'h3C; req_a = 1'b1;
        @(negedge clk);
        addr_a = 3'd1; data_a = 8'h55;
        run_frame("busy_first", 1'b0, 8'hAA, 8'h3C);
        @(negedge clk);
        req_a = 1'b0;
        run_frame("busy_held", 1'b0, 8'hA2, 8'h55);

        // Back-to-back frames with i_req continuously high
        @(negedge clk);
        addr_a = 3'd0; data_a = 8'h00; req_a = 1'b1;
        @(negedge clk);
        addr_a = 3'd7; data_a = 8'hFF;
        run_frame("b2b_first", 1'b0, 8'hA0, 8'h00);
        @(negedge clk);
        req_a = 1'b0;
        run_frame("b2b_second", 1'b0, 8'hAE, 8'hFF);

        // Reset in the first cycle of data bit 3 (a zero bit, so the jump high is visible)
        @(negedge clk);
        addr_a = 3'd3; data_a = 8'h00; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (58) @(negedge clk);
        check("pre_rst_tx_bit3", 32'(tx_a), 32'd0);
        nrst = 1'b0;
        #1;
        check("midrst_tx",    32'(tx_a),    32'd1);
        check("midrst_ready", 32'(ready_a), 32'd1);
        check("midrst_busy",  32'(busy_a),  32'd0);
        check("midrst_done",  32'(done_a),  32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_tx", 32'(tx_a), 32'd1);
        addr_a = 3'd2; data_a = 8'h81; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        run_frame("after_rst", 1'b0, 8'hA4, 8'h81);

        // Full-rate bit timing
        @(negedge clk);
        addr_b = 3'd5; data_b = 8'h3C; req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        run_frame("c868", 1'b1, 8'hAA, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_resp_tx.md
Name: uart_resp_tx

Overview:
- Transmit-side counterpart of the UART register command decoder.
- After the decoder handles a read command (cmd bit0=0, bits[3:1]=register address), it hands this block the address and the register value.
- This block builds a 2-byte response frame (header, data) and serialises it on the UART TX line as 8N1, LSB first.
- Sits between the register-access logic and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
- RESP_TAG, 4'hA, upper nibble of the response header byte.

Ports:
- i_clk  input  1  system clock
- i_nrst  input  1  asynchronous active-low reset
- i_req  input  1  response request; accepted only when o_ready=1
- i_addr  input  3  register address being answered
- i_data  input  8  register value
- o_ready  output  1  block idle, can accept i_req
- o_busy  output  1  frame in progress (equals ~o_ready)
- o_done  output  1  one-cycle pulse when the last stop bit completes
- o_tx  output  1  UART serial line, idle high

Behaviour:
- Reset (asynchronous): o_tx=1, o_ready=1, o_busy=0, o_done=0. Both FSMs go to IDLE. Baud and bit counters are cleared.
- Applies even mid-frame: the line returns high immediately, no partial byte is completed, and the latched request is discarded.
- Handshake:
  - On a rising edge with i_req=1 and o_ready=1, latch i_addr/i_data.
  - o_ready drops the next cycle.
  - i_req while busy is ignored; there is no queueing.
- Header byte = {RESP_TAG, addr[2:0], 1'b0}. Data byte = latched i_data.
- Frame FSM (top level):
  - IDLE: on accept -> HDR, issue header to byte sender.
  - HDR: wait for byte-sender done -> DATA, issue data byte.
  - DATA: wait for byte-sender done -> IDLE; pulse o_done; o_ready=1 the same cycle.
- Byte sender FSM: IDLE -> START -> BITS -> STOP -> IDLE.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - BITS: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles. The 3-bit bit index wraps 7 -> 0 on exit.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then done pulse.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
  - Width $clog2(CLKS_PER_BIT).
- Latency:
  - Start bit of the header appears on o_tx 1 cycle after the accept edge.
  - Between the header stop bit and the data start bit there is exactly 1 extra idle-high cycle (the byte-load cycle).
  - Total from accept to o_done = 20*CLKS_PER_BIT + 2 cycles.
  - A new i_req in the o_done cycle is accepted; back-to-back frames are legal.
- o_tx is driven from a flop (glitch-free).

Decomposition:
- uart_pkg (shared): frame-state enum {RT_IDLE, RT_HDR, RT_DATA}, byte-state enum {TX_IDLE, TX_START, TX_BITS, TX_STOP}, RESP_TAG default constant, UART_DATA_BITS=8.
- Sub-module uart_tx_byte: 8N1 serialiser.
  - Parameter: CLKS_PER_BIT.
  - Ports: i_clk, i_nrst, i_valid, i_byte[7:0], o_ready, o_done, o_tx.
  - Reused later by other TX paths.

Test Plan (CLKS_PER_BIT=4):
- Reset idle: hold i_nrst=0, then release, no req -> o_tx=1, o_ready=1, o_done=0 for 100 cycles.
- Single read response: i_addr=5, i_data=8'h3C.
  - Header 8'hAA: o_tx=0, then 0,1,0,1,0,1,0,1, then 1, each bit 4 cycles.
  - 1 idle cycle.
  - Data: 0, then 0,0,1,1,1,1,0,0, then 1.
  - o_done pulses at cycle 82 after accept.
- Busy rejection: i_req held high with a different addr/data mid-frame -> transmitted bytes unchanged; the held request is accepted only in the o_done cycle.
- Back-to-back: addr=0/data=8'h00 then addr=7/data=8'hFF with i_req continuously high.
  - Headers 8'hA0 and 8'hAE, no extra gap beyond 1 load cycle per byte.
  - Two o_done pulses 82 cycles apart.
- Reset mid-frame: assert i_nrst during data bit 3 -> o_tx=1 asynchronously, o_ready=1. After release, a new request (addr=2, data=8'h81) sends a correct frame (header 8'hA4).
- Bit timing check: CLKS_PER_BIT=868 -> every o_tx bit period measured as exactly 868 cycles (the inter-byte stop is 869).
